// File: rtl/mlp_engine_pkg.sv
// Shared configuration for mlp_engine: layer geometry, flattened weight/bias ROM
// contents, ROM offset tables and the controller state type.
// Current build: two-layer 2-3-2 network, ReLU on layer 0 only.
package mlp_engine_pkg;

    localparam int NUM_LAYERS  = 2;
    localparam int MAX_NEURONS = 4;

    localparam int LAYER_IN  [NUM_LAYERS] = '{2, 3};
    localparam int LAYER_OUT [NUM_LAYERS] = '{3, 2};
    localparam bit RELU_EN   [NUM_LAYERS] = '{1'b1, 1'b0};

    // First entry of each layer's block in WEIGHTS (neuron-major, k innermost) and BIAS.
    localparam int WOFF [NUM_LAYERS] = '{0, 6};
    localparam int BOFF [NUM_LAYERS] = '{0, 3};

    localparam int NUM_WEIGHTS = 12;
    localparam int NUM_BIAS    = 5;

    // Q(WIDTH-NFRAC).NFRAC values; 1024 == 1.0 at NFRAC = 10.
    localparam int WEIGHTS [NUM_WEIGHTS] = '{
        1024,     0,                // L0 n0
           0,  1024,                // L0 n1
         512,   512,                // L0 n2
        1024, -2048,    0,          // L1 n0
        -512,     0, 2048           // L1 n1
    };

    localparam int BIAS [NUM_BIAS] = '{0, 0, 0, 0, 10};

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StWrite,
        StDone
    } mlp_state_t;

    // Accumulator wide enough that no partial sum can overflow.
    function automatic int unsigned acc_width(int unsigned width, int unsigned max_neurons);
        return 2 * width + $clog2(max_neurons) + 1;
    endfunction

endpackage

// File: rtl/mlp_mac_unit.sv
// Signed multiply-accumulate for mlp_engine: bias preload, one product per
// cycle, and a combinational round / saturate / ReLU view of the accumulator.
module mlp_mac_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NFRAC = 10,
    parameter int unsigned ACC_W = 39
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic signed [WIDTH-1:0] bias_i,
    input  logic                    mac_i,
    input  logic signed [WIDTH-1:0] act_i,
    input  logic signed [WIDTH-1:0] weight_i,
    input  logic                    relu_i,
    output logic signed [WIDTH-1:0] result_o
);

    localparam logic signed [WIDTH-1:0] OutMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] OutMin = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-WIDTH){1'b0}}, OutMax};
    localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-WIDTH){1'b1}}, OutMin};
    localparam logic signed [ACC_W-1:0] Half   = {{(ACC_W-1){1'b0}}, 1'b1} << (NFRAC-1);

    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext, bias_ext, rounded, shifted;
    logic signed [WIDTH-1:0]   sat;

    // Full-width product; the low 2*WIDTH bits of the extended product are exact.
    assign prod = $signed({{WIDTH{act_i[WIDTH-1]}}, act_i})
                * $signed({{WIDTH{weight_i[WIDTH-1]}}, weight_i});

    assign prod_ext = $signed({{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod});
    assign bias_ext = $signed({{(ACC_W-WIDTH){bias_i[WIDTH-1]}}, bias_i}) <<< NFRAC;

    // Round half up, then arithmetic shift back to the activation format.
    assign rounded = acc_q + Half;
    assign shifted = rounded >>> NFRAC;

    // Next accumulator value: preload has priority over accumulation.
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = bias_ext;
        end else if (mac_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Saturate to the word range, then optional ReLU.
    always_comb begin
        if (shifted > SatMax) begin
            sat = OutMax;
        end else if (shifted < SatMin) begin
            sat = OutMin;
        end else begin
            sat = shifted[WIDTH-1:0];
        end
        result_o = (relu_i && sat[WIDTH-1]) ? '0 : sat;
    end

endmodule

// File: rtl/mlp_engine.sv
// Time-multiplexed dense-layer MLP: one MAC walks every neuron of every layer,
// ping-ponging activations between two banks; valid/ready on both sides.
module mlp_engine #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NFRAC       = 10,
    parameter int unsigned NUM_LAYERS  = mlp_engine_pkg::NUM_LAYERS,
    parameter int unsigned IN_SIZE     = mlp_engine_pkg::LAYER_IN[0],
    parameter int unsigned OUT_SIZE    = mlp_engine_pkg::LAYER_OUT[mlp_engine_pkg::NUM_LAYERS-1],
    parameter int unsigned MAX_NEURONS = mlp_engine_pkg::MAX_NEURONS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*IN_SIZE-1:0]  input_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*OUT_SIZE-1:0] output_data,
    output logic                      busy
);

    import mlp_engine_pkg::*;

    localparam int unsigned AccW = acc_width(WIDTH, MAX_NEURONS);
    localparam int unsigned NW   = (MAX_NEURONS > 1) ? $clog2(MAX_NEURONS) : 1;
    localparam int unsigned LW   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned WiW  = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
    localparam int unsigned BiW  = (NUM_BIAS > 1) ? $clog2(NUM_BIAS) : 1;

    mlp_state_t state_q, state_d;

    logic [LW-1:0] layer_q, layer_d;
    logic [NW-1:0] neuron_q, neuron_d;
    logic [NW-1:0] k_q, k_d;
    logic          sel_q, sel_d;    // 0: read bank A / write bank B; 1: the reverse

    logic signed [WIDTH-1:0] bank_a_q [MAX_NEURONS];
    logic signed [WIDTH-1:0] bank_b_q [MAX_NEURONS];
    logic signed [WIDTH-1:0] out_q    [OUT_SIZE];
    logic signed [WIDTH-1:0] out_d    [OUT_SIZE];

    logic                    accept;
    logic                    last_k, last_neuron, last_layer;
    int                      cur_in, cur_out;
    logic [WiW-1:0]          w_idx;
    logic [BiW-1:0]          b_idx;
    logic signed [WIDTH-1:0] weight, bias_nx, src_act, result;
    logic                    relu;
    logic                    mac_load, mac_en, wr_en;

    // Current-layer geometry and ROM addressing for weight and next bias.
    always_comb begin
        cur_in      = LAYER_IN[layer_q];
        cur_out     = LAYER_OUT[layer_q];
        last_k      = (int'(k_q) == cur_in - 1);
        last_neuron = (int'(neuron_q) == cur_out - 1);
        last_layer  = (int'(layer_q) == int'(NUM_LAYERS) - 1);
        relu        = RELU_EN[layer_q];
        w_idx       = WiW'(WOFF[layer_q] + int'(neuron_q) * cur_in + int'(k_q));
        if (state_q == StIdle) begin
            b_idx = BiW'(BOFF[0]);
        end else if (last_neuron && last_layer) begin
            b_idx = '0;
        end else if (last_neuron) begin
            b_idx = BiW'(BOFF[layer_q + 1'b1]);
        end else begin
            b_idx = BiW'(BOFF[layer_q] + int'(neuron_q) + 1);
        end
        weight  = WIDTH'(WEIGHTS[w_idx]);
        bias_nx = WIDTH'(BIAS[b_idx]);
        src_act = sel_q ? bank_b_q[k_q] : bank_a_q[k_q];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StMac;
            StMac:   if (last_k) state_d = StWrite;
            StWrite: state_d = (last_neuron && last_layer) ? StDone : StMac;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs and datapath strobes decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        mac_load  = 1'b0;
        mac_en    = 1'b0;
        wr_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                mac_load = in_valid;
            end
            StMac: begin
                busy   = 1'b1;
                mac_en = 1'b1;
            end
            StWrite: begin
                busy     = 1'b1;
                mac_load = 1'b1;
                wr_en    = 1'b1;
            end
            StDone:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Counter, bank-select and logit-register next state.
    always_comb begin
        layer_d  = layer_q;
        neuron_d = neuron_q;
        k_d      = k_q;
        sel_d    = sel_q;
        out_d    = out_q;
        if (accept) begin
            layer_d  = '0;
            neuron_d = '0;
            k_d      = '0;
            sel_d    = 1'b0;
        end else if (mac_en) begin
            k_d = k_q + 1'b1;
        end else if (wr_en) begin
            k_d = '0;
            if (last_layer) begin
                for (int i = 0; i < int'(OUT_SIZE); i++) begin
                    if (int'(neuron_q) == i) out_d[i] = result;
                end
            end
            if (!last_neuron) begin
                neuron_d = neuron_q + 1'b1;
            end else if (!last_layer) begin
                neuron_d = '0;
                layer_d  = layer_q + 1'b1;
                sel_d    = ~sel_q;
            end
        end
    end

    // Control and logit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            layer_q  <= '0;
            neuron_q <= '0;
            k_q      <= '0;
            sel_q    <= 1'b0;
            for (int i = 0; i < int'(OUT_SIZE); i++) out_q[i] <= '0;
        end else begin
            layer_q  <= layer_d;
            neuron_q <= neuron_d;
            k_q      <= k_d;
            sel_q    <= sel_d;
            out_q    <= out_d;
        end
    end

    // Activation banks: frame load into A, then one neuron write per WRITE cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < int'(IN_SIZE); i++) begin
                bank_a_q[i] <= input_data[i*WIDTH +: WIDTH];
            end
        end else if (wr_en && !last_layer) begin
            if (sel_q) begin
                bank_a_q[neuron_q] <= result;
            end else begin
                bank_b_q[neuron_q] <= result;
            end
        end
    end

    for (genvar g = 0; g < int'(OUT_SIZE); g++) begin : g_out
        assign output_data[g*WIDTH +: WIDTH] = out_q[g];
    end

    mlp_mac_unit #(
        .WIDTH (WIDTH),
        .NFRAC (NFRAC),
        .ACC_W (AccW)
    ) u_mac (
        .clk_i    (clk),
        .reset_i  (reset),
        .load_i   (mac_load),
        .bias_i   (bias_nx),
        .mac_i    (mac_en),
        .act_i    (src_act),
        .weight_i (weight),
        .relu_i   (relu),
        .result_o (result)
    );

endmodule

// File: tb/tb_mlp_engine.sv
// Directed bench for mlp_engine with the 2-3-2 package network:
//   h0 = relu(x0), h1 = relu(x1), h2 = relu(round((x0 + x1) / 2))
//   y0 = sat(h0 - 2*h1), y1 = sat(10 + round((4*h2 - h0) / 2))
// Frame latency is 3*(2+1) + 2*(3+1) = 17 edges.
module tb_mlp_engine;

    localparam int Lat = 17;

    typedef struct {
        string              name;
        logic signed [15:0] x0;
        logic signed [15:0] x1;
        logic signed [15:0] y0;
        logic signed [15:0] y1;
        bit                 early_rdy;
        bit                 hold_valid;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] output_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    vec_t vecs [8];

    mlp_engine #(
        .WIDTH       (16),
        .NFRAC       (10),
        .NUM_LAYERS  (2),
        .IN_SIZE     (2),
        .OUT_SIZE    (2),
        .MAX_NEURONS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .input_data  (input_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .output_data (output_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(string n, int a, int b, int c, int d, bit e, bit h);
        vec_t v;
        v.name       = n;
        v.x0         = 16'(a);
        v.x1         = 16'(b);
        v.y0         = 16'(c);
        v.y1         = 16'(d);
        v.early_rdy  = e;
        v.hold_valid = h;
        return v;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called sampled #1 after an edge with the DUT in IDLE; returns edges from accept
    // to out_valid, with the DUT left in DONE.
    task automatic run_frame(input string name, input logic signed [15:0] a,
                             input logic signed [15:0] b, input bit early, input bit hold,
                             output int lat);
        check({name, "_in_ready_idle"}, in_ready, 1);
        in_valid   = 1'b1;
        input_data = {b, a};
        out_ready  = early;
        @(posedge clk);
        #1;
        check({name, "_busy_mac"}, busy, 1);
        check({name, "_in_ready_mac"}, in_ready, 0);
        if (hold) begin
            input_data = ~input_data;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        check({name, "_in_ready_done"}, in_ready, 0);
        check({name, "_busy_done"}, busy, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_in_ready_after"}, in_ready, 1);
        check({name, "_out_valid_after"}, out_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] held;
        logic [31:0] exp_bp;

        vecs[0] = mk("ident",   1536, -2048,   1536,   -758, 1'b0, 1'b0);
        vecs[1] = mk("rnd_neg",    1,    -1,      1,     10, 1'b1, 1'b0);
        vecs[2] = mk("rnd_pos",    3,    -2,      3,     11, 1'b0, 1'b1);
        vecs[3] = mk("sat_pos", 30000, 30000, -30000,  32767, 1'b0, 1'b0);
        vecs[4] = mk("sat_neg",    0, 20000, -32768,  20010, 1'b0, 1'b0);
        vecs[5] = mk("relu",    -100,  -200,      0,     10, 1'b1, 1'b0);
        vecs[6] = mk("extreme", -32768, 32767, -32768,    10, 1'b0, 1'b0);
        vecs[7] = mk("mix",     2048,  1024,      0,   2058, 1'b0, 1'b0);

        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        input_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_output_data", output_data, 0);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].name, vecs[i].x0, vecs[i].x1, vecs[i].early_rdy,
                      vecs[i].hold_valid, lat);
            check({vecs[i].name, "_latency"}, lat, Lat);
            check({vecs[i].name, "_out_valid"}, out_valid, 1);
            check({vecs[i].name, "_y0"}, $signed(output_data[15:0]), vecs[i].y0);
            check({vecs[i].name, "_y1"}, $signed(output_data[31:16]), vecs[i].y1);
            finish_frame(vecs[i].name);
        end

        // Backpressure: DONE held 20 cycles with stray in_valid pulses.
        run_frame("bp", 16'sd2048, 16'sd1024, 1'b0, 1'b0, lat);
        check("bp_latency", lat, Lat);
        exp_bp = {16'd2058, 16'd0};
        held   = output_data;
        for (int c = 0; c < 20; c++) begin
            in_valid   = (c % 3 == 0);
            input_data = $urandom;
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_output_stable", output_data, held);
            check("bp_in_ready", in_ready, 0);
        end
        check("bp_output_value", output_data, exp_bp);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_release", in_ready, 1);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_queued_busy", busy, 0);
        check("bp_no_queued_valid", out_valid, 0);

        // Reset five cycles into MAC; logits from the previous frame are non-zero.
        in_valid   = 1'b1;
        input_data = {16'sd1024, 16'sd2048};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy_before_reset", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_output_data", output_data, 0);

        run_frame("fresh", 16'sd0, 16'sd20000, 1'b0, 1'b0, lat);
        check("fresh_latency", lat, Lat);
        check("fresh_y0", $signed(output_data[15:0]), -32768);
        check("fresh_y1", $signed(output_data[31:16]), 20010);
        finish_frame("fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
